// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Writer-side companion to the single-cycle core's instruction fetch path.
//   A byte stream arriving over a valid/ready handshake is packed big-endian
//   into 32-bit instruction words. Each word is written to program memory at
//   sequential word-aligned byte addresses (0, 4, 8, ...). The core is held
//   out of execution (core_run_o=0) until the whole program has been
//   written, then released.
//
// Handshake:
//   A byte transfers on a rising clk edge where byte_valid_i and
//   byte_ready_o are both 1. The source must hold byte_data_i stable while
//   byte_valid_i=1 and byte_ready_o=0. byte_ready_o never depends on
//   byte_valid_i.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start_i        request a load session (honoured in IDLE and DONE only)
//   length_i       number of words to load, sampled with an honoured start_i
//   byte_valid_i   byte_data_i carries a valid byte
//   byte_data_i    stream byte
//   byte_ready_o   loader can accept a byte this cycle
//   mem_write_o    program memory write strobe, one cycle per word
//   mem_address_o  byte address of the word being written
//   mem_data_o     instruction word being written
//   busy_o         load session in progress
//   done_o         last load completed successfully
//   error_o        last start_i was rejected (sticky)
//   core_run_o     core may execute; drives the core's reset
//   state_o        current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [15:0]           length_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [31:0]           mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  core_run_o,
    output logic [1:0]            state_o
);

    // Word index must be able to hold MEMORY_DEPTH itself (the final count).
    localparam int IDX_W = $clog2(MEMORY_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [IDX_W-1:0]      r_len;
    logic [IDX_W-1:0]      r_word_idx;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_shift;
    logic [31:0]           r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_error;

    logic                  w_len_ok;
    logic                  w_start_seen;
    logic                  w_start_ok;
    logic                  w_byte_fire;
    logic                  w_last_byte;
    logic [31:0]           w_word;
    logic [IDX_W-1:0]      w_word_idx_inc;

    // A start is only looked at while no session is running.
    assign w_len_ok       = (length_i != 16'd0) &&
                            (int'({16'd0, length_i}) <= MEMORY_DEPTH);
    assign w_start_seen   = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_start_ok     = w_start_seen && w_len_ok;
    assign w_byte_fire    = (r_state == S_RECV) && byte_valid_i;
    assign w_last_byte    = w_byte_fire && (r_byte_cnt == 2'd3);
    // New byte enters at [7:0]; after four bytes the first one sits in [31:24].
    assign w_word         = {r_shift[23:0], byte_data_i};
    assign w_word_idx_inc = r_word_idx + IDX_W'(1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_RECV;
                end
            end
            S_RECV: begin
                if (w_last_byte) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_word_idx_inc == r_len) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RECV;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    w_next_state = w_len_ok ? S_RECV : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, assembly register, write address/data, error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= 2'd0;
            r_shift    <= 32'd0;
            r_data     <= 32'd0;
            r_addr     <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_start_seen) begin
                // Error reflects only the most recent start that was looked at.
                r_error <= !w_len_ok;
            end

            if (w_start_ok) begin
                r_len      <= IDX_W'(length_i);
                r_word_idx <= '0;
                r_byte_cnt <= 2'd0;
                r_shift    <= 32'd0;
            end

            if (w_byte_fire) begin
                r_shift    <= w_word;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            // Address/data are loaded as the word completes so they are
            // already valid during the WRITE cycle, then simply held.
            if (w_last_byte) begin
                r_data <= w_word;
                r_addr <= ADDR_WIDTH'({r_word_idx, 2'b00});
            end

            if (r_state == S_WRITE) begin
                r_word_idx <= w_word_idx_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign byte_ready_o  = (r_state == S_RECV);
    assign mem_write_o   = (r_state == S_WRITE);
    assign busy_o        = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done_o        = (r_state == S_DONE);
    assign core_run_o    = (r_state == S_DONE);
    assign error_o       = r_error;
    assign mem_address_o = r_addr;
    assign mem_data_o    = r_data;
    assign state_o       = r_state;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Reference model: a session-level view of the loader. It tracks only
// "idle / loading / done", the sticky error flag, the bytes received so far
// in the current word and the number of words written. From those it states
// what every output must be on every cycle, and queues the (address, word)
// pair each completed group of four bytes must produce one cycle later.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int DEPTH = 32;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] length_i = 16'd0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        core_run_o;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    program_loader #(
        .MEMORY_DEPTH (DEPTH),
        .ADDR_WIDTH   (32)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .start_i       (start_i),
        .length_i      (length_i),
        .byte_valid_i  (byte_valid_i),
        .byte_data_i   (byte_data_i),
        .byte_ready_o  (byte_ready_o),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .core_run_o    (core_run_o),
        .state_o       (state_o)
    );

    // ------------------------------------------------------------------
    // Scoreboard / model state
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_LOAD, M_DONE} mphase_t;

    int          n_checks = 0;
    int          n_pass = 0;
    mphase_t     m_phase = M_IDLE;
    int          m_len = 0;
    int          m_words = 0;
    int          m_nb = 0;
    logic [31:0] m_word = 32'd0;
    logic        m_err = 1'b0;
    logic        m_wr_next = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] m_log[$];

    logic [7:0]  t1_bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    logic [7:0]  t2_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0]  t4_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  t5_bytes [4] = '{8'h5A, 8'hC3, 8'h0F, 8'h96};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = M_IDLE;
        m_err     = 1'b0;
        m_wr_next = 1'b0;
        m_nb      = 0;
        m_words   = 0;
        m_len     = 0;
        exp_q.delete();
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        mphase_t     ph;
        logic [63:0] e;
        if (!rst_n) begin
            chk("reset_ctrl", {byte_ready_o, mem_write_o, busy_o, done_o, error_o,
                               core_run_o, state_o}, 0);
            chk("reset_addr", mem_address_o, 0);
            chk("reset_data", mem_data_o, 0);
        end else begin
            ph = m_phase;
            chk("mem_write", mem_write_o, m_wr_next);
            if (m_wr_next) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr_data", {mem_address_o, mem_data_o}, e);
                    m_log.push_back(e);
                end
            end
            chk("byte_ready", byte_ready_o, (ph == M_LOAD) && !m_wr_next);
            chk("busy", busy_o, ph == M_LOAD);
            chk("done", done_o, ph == M_DONE);
            chk("core_run", core_run_o, ph == M_DONE);
            chk("error", error_o, m_err);
            chk("addr_align", mem_address_o[1:0], 0);

            // Advance the model across the coming rising edge.
            if (m_wr_next) begin
                m_wr_next = 1'b0;
                m_words++;
                if (m_words == m_len) m_phase = M_DONE;
            end else if (ph == M_LOAD && byte_valid_i) begin
                m_word = {m_word[23:0], byte_data_i};
                m_nb++;
                if (m_nb == 4) begin
                    exp_q.push_back({32'(m_words * 4), m_word});
                    m_nb      = 0;
                    m_wr_next = 1'b1;
                end
            end
            if (start_i && ph != M_LOAD) begin
                if (int'(length_i) >= 1 && int'(length_i) <= DEPTH) begin
                    m_phase = M_LOAD;
                    m_len   = int'(length_i);
                    m_words = 0;
                    m_nb    = 0;
                    m_err   = 1'b0;
                end else begin
                    m_err   = 1'b1;
                    m_phase = M_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all return at posedge + 1)
    // ------------------------------------------------------------------
    task automatic do_start(input int len);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        length_i     = 16'(len);
        @(posedge clk); #1;
        start_i      = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic r;
        logic fin;
        n   = 0;
        fin = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (!fin) begin
            @(negedge clk);
            r = byte_ready_o;
            @(posedge clk); #1;
            n++;
            if (r) begin
                fin = 1'b1;
            end else if (n > 50) begin
                chk("send_byte_timeout", 0, 1);
                fin = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_o !== 1'b1) chk("wait_done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] v;
        int          len;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two back-to-back words.
        m_log.delete();
        do_start(2);
        for (int i = 0; i < 8; i++) send_byte(t1_bytes[i]);
        byte_valid_i = 1'b0;
        wait_done(100);
        chk("t1_count", m_log.size(), 2);
        chk("t1_word0", m_log[0], {32'h0, 32'h20080005});
        chk("t1_word1", m_log[1], {32'h4, 32'h01095020});
        chk("t1_done_run", {done_o, core_run_o}, 2'b11);

        // Single word with gaps between bytes.
        m_log.delete();
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(3);
            send_byte(t2_bytes[i]);
        end
        byte_valid_i = 1'b0;
        wait_done(100);
        chk("t2_count", m_log.size(), 1);
        chk("t2_word0", m_log[0], {32'h0, 32'hAABBCCDD});

        // Rejected lengths, then a full-depth load.
        do_start(0);
        idle(2);
        chk("t3_err_len0", {error_o, byte_ready_o, state_o}, {1'b1, 1'b0, 2'd0});
        do_start(DEPTH + 1);
        idle(2);
        chk("t3_err_len33", {error_o, byte_ready_o, busy_o, state_o}, {1'b1, 1'b0, 1'b0, 2'd0});
        m_log.delete();
        do_start(DEPTH);
        chk("t3_err_cleared", error_o, 0);
        for (int i = 0; i < DEPTH * 4; i++) begin
            idle($urandom_range(0, 2));
            send_byte(8'($urandom_range(0, 255)));
        end
        byte_valid_i = 1'b0;
        wait_done(2000);
        chk("t3_count", m_log.size(), DEPTH);
        v = m_log[DEPTH - 1];
        chk("t3_last_addr", v[63:32], 32'h7C);

        // Reset in the middle of the first word of a 3-word load.
        do_start(3);
        send_byte(8'hDE);
        send_byte(8'hAD);
        byte_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_ctrl", {byte_ready_o, mem_write_o, busy_o, done_o, error_o, core_run_o}, 0);
        chk("t4_async_addr_data", {mem_address_o, mem_data_o}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        m_log.delete();
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(t4_bytes[i]);
        byte_valid_i = 1'b0;
        wait_done(100);
        chk("t4_count", m_log.size(), 1);
        chk("t4_word0", m_log[0], {32'h0, 32'h11223344});

        // Restart from DONE; start during RECV is ignored.
        m_log.delete();
        do_start(1);
        chk("t5_released", {done_o, core_run_o}, 2'b00);
        send_byte(t5_bytes[0]);
        do_start(7);
        for (int i = 1; i < 4; i++) send_byte(t5_bytes[i]);
        byte_valid_i = 1'b0;
        wait_done(100);
        chk("t5_count", m_log.size(), 1);
        chk("t5_word0", m_log[0], {32'h0, 32'h5AC30F96});
        chk("t5_done", {done_o, core_run_o}, 2'b11);

        // Random sessions.
        for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_start(($urandom_range(0, 1) == 0) ? 0 : DEPTH + 1 + $urandom_range(0, 200));
                idle(2);
            end
            len = $urandom_range(1, 6);
            do_start(len);
            for (int w = 0; w < len; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((w != 0 || b != 0) && $urandom_range(0, 5) == 0) begin
                        do_start($urandom_range(0, 40));
                    end else begin
                        idle($urandom_range(0, 2));
                    end
                    send_byte(8'($urandom_range(0, 255)));
                end
            end
            byte_valid_i = 1'b0;
            wait_done(500);
        end

        idle(3);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
